// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types for the counter sequencer: command opcodes and controller states.
// Imported by the controller, its command interface and the counter datapath.
package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_START  = 2'b00,
    OP_PAUSE  = 2'b01,
    OP_RESUME = 2'b10,
    OP_ABORT  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HOLD = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command port of the counter sequencer: valid/ready handshake plus START payload.
// master drives commands, slave (the controller) returns cmd_ready.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  import counter_seq_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;
  logic             cmd_up;

  modport master (
    output cmd_valid, cmd_op, cmd_start, cmd_end, cmd_up,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_start, cmd_end, cmd_up,
    output cmd_ready
  );

endinterface

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer that loads, steps and stops an external WIDTH-bit counter.
// Done one cycle after count==end is seen in RUN; cmd_ready drops only in the LOAD cycle.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_seq_ctrl_if.slave    cmd,
  input  logic [WIDTH-1:0]     count,
  output logic                 cnt_load,
  output logic [WIDTH-1:0]     cnt_load_val,
  output logic                 cnt_en,
  output logic                 cnt_up,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic             up_q, up_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             at_end;

  assign cmd.cmd_ready = (state_q != ST_LOAD);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign at_end        = (count == end_q);

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    up_d    = up_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: begin
              start_d = cmd.cmd_start;
              end_d   = cmd.cmd_end;
              up_d    = cmd.cmd_up;
              state_d = ST_LOAD;
            end
            OP_ABORT: state_d = ST_IDLE;
            default:  err_d   = 1'b1;
          endcase
        end
      end

      ST_LOAD: state_d = ST_RUN;

      ST_RUN: begin
        // ABORT beats reaching the terminal count; any other command there is dropped.
        if (accept && cmd.cmd_op == OP_ABORT) begin
          state_d = ST_IDLE;
        end else begin
          if (at_end) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
          if (accept) begin
            if (cmd.cmd_op == OP_PAUSE && !at_end) begin
              state_d = ST_HOLD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      ST_HOLD: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_RESUME: state_d = ST_RUN;
            OP_ABORT:  state_d = ST_IDLE;
            default:   err_d   = 1'b1;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      end_q   <= '0;
      up_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      up_q    <= up_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Counter controls decode straight from the async-reset state so a reset cuts them at once.
  assign cnt_load     = (state_q == ST_LOAD);
  assign cnt_load_val = start_q;
  assign cnt_en       = (state_q == ST_RUN) && !at_end;
  assign cnt_up       = up_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule
